// File: rtl/reaction_timer_mc.sv
// reaction_timer_mc: N_CH-player reaction timer with shared go lamp, random pre-go delay and tick prescaler.
// Optional macro BEST_TIME_EN adds per-channel best reaction time registers that persist across rounds.
module reaction_timer_mc #(
   parameter int N_CH         = 2,
   parameter int DLY_W        = 14,
   parameter int T_W          = 10,
   parameter int MAX_TIME     = 999,
   parameter int CLK_PER_TICK = 50000,
   localparam int WIDX        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic                abort,
   input  logic [DLY_W-1:0]    rand_delay,
   input  logic [N_CH-1:0]     press,
   output logic                go,
   output logic                busy,
   output logic                done,
   output logic [N_CH*T_W-1:0] react_time,
   output logic [N_CH-1:0]     valid,
   output logic [N_CH-1:0]     false_start,
   output logic [N_CH-1:0]     overflow,
   output logic [WIDX-1:0]     winner_idx,
   output logic                winner_valid
`ifdef BEST_TIME_EN
   ,
   output logic [N_CH*T_W-1:0] best_time,
   output logic [N_CH-1:0]     best_valid
`endif
);

   localparam int PW = $clog2(CLK_PER_TICK);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_DELAY = 3'd2,
      S_ARMED = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_r, state_s;
   logic [PW-1:0]       presc_r;
   logic [DLY_W-1:0]    dly_r, delay_cnt_r;
   logic [T_W-1:0]      react_cnt_r, win_time_s;
   logic [N_CH-1:0]     press_q_r, resolved_r, edge_s, resolved_s, valid_s, fs_s, ov_s;
   logic [N_CH*T_W-1:0] rt_s;
   logic [WIDX-1:0]     win_idx_s;
   logic                tick_s, timeout_s, abort_s, start_acc_s;
   logic                go_s, busy_s, done_s, win_ok_s;

   assign edge_s      = press & ~press_q_r;
   assign tick_s      = (presc_r == PW'(CLK_PER_TICK - 1));
   assign timeout_s   = (state_r == S_ARMED) && tick_s && (react_cnt_r == T_W'(MAX_TIME));
   assign abort_s     = abort && (state_r != S_IDLE);
   assign start_acc_s = start && !abort && ((state_r == S_IDLE) || (state_r == S_DONE));

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_r <= S_IDLE;
      else       state_r <= state_s;
   end

   // Next-state logic; abort beats start and any press resolution
   always_comb begin
      state_s = state_r;
      if (abort_s) begin
         state_s = S_IDLE;
      end else if (start_acc_s) begin
         state_s = S_CLEAR;
      end else begin
         case (state_r)
            S_CLEAR: state_s = S_DELAY;
            S_DELAY: begin
               if (&resolved_s)                 state_s = S_DONE;
               else if (delay_cnt_r == dly_r)   state_s = S_ARMED;
               else                             state_s = S_DELAY;
            end
            S_ARMED: begin
               if (&resolved_s) state_s = S_DONE;
               else             state_s = S_ARMED;
            end
            default: state_s = state_r;
         endcase
      end
   end

   // Output logic, evaluated on the next state so the registered outputs line up with it
   always_comb begin
      go_s   = (state_s == S_ARMED);
      busy_s = (state_s == S_CLEAR) || (state_s == S_DELAY) || (state_s == S_ARMED);
      done_s = (state_s == S_DONE) && (state_r != S_DONE);
   end

   // Per-channel result update; a capture on the timeout tick wins over overflow
   always_comb begin
      valid_s    = valid;
      fs_s       = false_start;
      ov_s       = overflow;
      rt_s       = react_time;
      resolved_s = resolved_r;
      case (state_r)
         S_DELAY: begin
            fs_s       = false_start | edge_s;
            resolved_s = resolved_r | edge_s;
         end
         S_ARMED: begin
            for (int i = 0; i < N_CH; i++) begin
               if (edge_s[i] && !resolved_r[i]) begin
                  valid_s[i]            = 1'b1;
                  rt_s[i*T_W +: T_W]    = react_cnt_r;
                  resolved_s[i]         = 1'b1;
               end else if (timeout_s && !resolved_r[i]) begin
                  ov_s[i]               = 1'b1;
                  rt_s[i*T_W +: T_W]    = T_W'(MAX_TIME);
                  resolved_s[i]         = 1'b1;
               end else begin
                  resolved_s[i]         = resolved_r[i];
               end
            end
         end
         default: resolved_s = resolved_r;
      endcase
   end

   // Winner search over the results about to be registered; strict compare keeps the lowest index on ties
   always_comb begin
      win_idx_s  = '0;
      win_ok_s   = 1'b0;
      win_time_s = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (valid_s[i] && (!win_ok_s || (rt_s[i*T_W +: T_W] < win_time_s))) begin
            win_idx_s  = WIDX'(i);
            win_ok_s   = 1'b1;
            win_time_s = rt_s[i*T_W +: T_W];
         end else begin
            win_ok_s   = win_ok_s;
         end
      end
   end

   // Datapath: prescaler, counters, results and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         press_q_r    <= '0;
         presc_r      <= '0;
         delay_cnt_r  <= '0;
         react_cnt_r  <= '0;
         dly_r        <= '0;
         resolved_r   <= '0;
         go           <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         react_time   <= '0;
         valid        <= '0;
         false_start  <= '0;
         overflow     <= '0;
         winner_idx   <= '0;
         winner_valid <= 1'b0;
      end else begin
         press_q_r <= press;
         go        <= go_s;
         busy      <= busy_s;
         done      <= done_s;
         if ((state_s != state_r) || tick_s || !((state_r == S_DELAY) || (state_r == S_ARMED)))
            presc_r <= '0;
         else
            presc_r <= presc_r + PW'(1);
         if (start_acc_s || abort_s) begin
            delay_cnt_r  <= '0;
            react_cnt_r  <= '0;
            resolved_r   <= '0;
            react_time   <= '0;
            valid        <= '0;
            false_start  <= '0;
            overflow     <= '0;
            winner_idx   <= '0;
            winner_valid <= 1'b0;
            dly_r        <= start_acc_s ? rand_delay : dly_r;
         end else begin
            resolved_r  <= resolved_s;
            react_time  <= rt_s;
            valid       <= valid_s;
            false_start <= fs_s;
            overflow    <= ov_s;
            if (done_s) begin
               winner_idx   <= win_idx_s;
               winner_valid <= win_ok_s;
            end
            if ((state_r == S_DELAY) && tick_s && (delay_cnt_r != dly_r))
               delay_cnt_r <= delay_cnt_r + DLY_W'(1);
            if ((state_r == S_ARMED) && tick_s && (react_cnt_r != T_W'(MAX_TIME)))
               react_cnt_r <= react_cnt_r + T_W'(1);
         end
      end
   end

`ifdef BEST_TIME_EN
   // Best times survive CLEAR and abort; only rstn clears them
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         best_time  <= '0;
         best_valid <= '0;
      end else if (done_s) begin
         for (int i = 0; i < N_CH; i++) begin
            if (valid_s[i] && (!best_valid[i] || (rt_s[i*T_W +: T_W] < best_time[i*T_W +: T_W]))) begin
               best_time[i*T_W +: T_W] <= rt_s[i*T_W +: T_W];
               best_valid[i]           <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_reaction_timer_mc.sv
// Scoreboard bench for reaction_timer_mc: stimulus pushes expected round results, a monitor checks them on done.
`timescale 1ns/1ps
module tb_reaction_timer_mc;
   localparam int N_CH = 2, DLY_W = 14, T_W = 10, MAX_TIME = 20, CPT = 4, WIDX = 1;

   logic                clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
   logic [DLY_W-1:0]    rand_delay = '0;
   logic [N_CH-1:0]     press = '0;
   logic                go, busy, done, winner_valid;
   logic [N_CH*T_W-1:0] react_time;
   logic [N_CH-1:0]     valid, false_start, overflow;
   logic [WIDX-1:0]     winner_idx;
`ifdef BEST_TIME_EN
   logic [N_CH*T_W-1:0] best_time;
   logic [N_CH-1:0]     best_valid;
`endif

   typedef struct packed {
      logic [N_CH*T_W-1:0] rt;
      logic [N_CH-1:0]     vld, fs, ov;
      logic [WIDX-1:0]     widx;
      logic                wv;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0, n_fail = 0, done_cnt = 0;
   logic prev_done = 1'b0;

   always #5 clk = ~clk;

   reaction_timer_mc #(.N_CH(N_CH), .DLY_W(DLY_W), .T_W(T_W), .MAX_TIME(MAX_TIME), .CLK_PER_TICK(CPT)) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .rand_delay(rand_delay), .press(press),
      .go(go), .busy(busy), .done(done), .react_time(react_time), .valid(valid),
      .false_start(false_start), .overflow(overflow), .winner_idx(winner_idx), .winner_valid(winner_valid)
`ifdef BEST_TIME_EN
      , .best_time(best_time), .best_valid(best_valid)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [T_W-1:0] rt1, input logic [T_W-1:0] rt0, input logic [1:0] vld,
                           input logic [1:0] fs, input logic [1:0] ov, input logic widx, input logic wv);
      exp_t e;
      e.rt = {rt1, rt0}; e.vld = vld; e.fs = fs; e.ov = ov; e.widx = widx; e.wv = wv;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [DLY_W-1:0] dly);
      rand_delay = dly;
      start = 1'b1;
      wait_cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_go(output int n);
      n = 0;
      while (!go && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      check("go_rise_bound", {63'd0, go}, 64'd1);
   endtask

   task automatic wait_idle(output logic saw_go);
      int n;
      n = 0;
      saw_go = 1'b0;
      while (busy && n < 2000) begin
         saw_go = saw_go | go;
         @(posedge clk); #1; n++;
      end
      check("idle_bound", {63'd0, busy}, 64'd0);
   endtask

   // Monitor: every done pulse must match the oldest expected round
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn && done) begin
            done_cnt++;
            check("done_single_cycle", {63'd0, prev_done}, 64'd0);
            check("done_expected", {63'd0, (exp_q.size() > 0)}, 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("react_time",   react_time,   e.rt);
               check("valid",        valid,        e.vld);
               check("false_start",  false_start,  e.fs);
               check("overflow",     overflow,     e.ov);
               check("winner_idx",   winner_idx,   e.widx);
               check("winner_valid", winner_valid, e.wv);
               check("go_low_done",  go,           0);
            end
         end
         prev_done = done;
      end
   end

   initial begin
      int   n;
      int   d0;
      logic saw;
      int   best_t[3] = '{9, 4, 6};

      #3;
      check("reset_outputs", {go, busy, done, react_time, valid, false_start, overflow, winner_idx, winner_valid}, 0);
      wait_cyc(2);
      rstn = 1'b1;
      wait_cyc(2);

      // Two legal presses at 5 and 8 ticks; go latency = 2 (start, CLEAR) + 3*4 + 1 - 1 sampling offset
      push_exp(10'd8, 10'd5, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
      do_start(14'd3);
      wait_go(n);
      check("go_latency_d3", n, 14);
      wait_cyc(20); press = 2'b01;
      wait_cyc(12); press = 2'b11;
      wait_idle(saw);
      press = 2'b00; wait_cyc(2);

      // Ch1 false start, ch0 legal at 7 ticks
      push_exp(10'd0, 10'd7, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1);
      do_start(14'd3);
      wait_cyc(3); press = 2'b10;
      wait_go(n);
      wait_cyc(28); press = 2'b11;
      wait_idle(saw);
      press = 2'b00; wait_cyc(2);

      // Both false start: round ends without go
      push_exp(10'd0, 10'd0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
      do_start(14'd3);
      wait_cyc(2); press = 2'b11;
      wait_idle(saw);
      check("no_go_all_false", {63'd0, saw}, 64'd0);
      press = 2'b00; wait_cyc(2);

      // Timeout: done arrives with the 21st ARMED tick, i.e. 84 cycles after go
      push_exp(10'd20, 10'd20, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
      do_start(14'd1);
      wait_go(n);
      n = 0;
      while (!done && n < 500) begin
         @(posedge clk); #1; n++;
      end
      check("timeout_latency", n, 84);
      wait_cyc(2);

      // Simultaneous edges at react_cnt 6, with a start pulse mid-round that must be ignored
      push_exp(10'd6, 10'd6, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
      do_start(14'd2);
      wait_go(n);
      wait_cyc(8); start = 1'b1;
      wait_cyc(1); start = 1'b0;
      wait_cyc(2);
      check("start_ignored", {go, busy}, 2'b11);
      wait_cyc(13); press = 2'b11;
      wait_idle(saw);
      press = 2'b00; wait_cyc(2);

      // Async reset while ARMED clears every output at once
      do_start(14'd1);
      wait_go(n);
      wait_cyc(8); press = 2'b01;
      wait_cyc(2);
      check("valid_before_reset", valid, 2'b01);
      #1 rstn = 1'b0;
      #1;
      check("async_reset_clears", {go, busy, done, react_time, valid, false_start, overflow, winner_idx, winner_valid}, 0);
      press = 2'b00;
      wait_cyc(2); rstn = 1'b1;
      wait_cyc(2);

      // Three rounds with ch0 times 9, 4, 6 (ch1 false-starts)
      for (int r = 0; r < 3; r++) begin
         push_exp(10'd0, T_W'(best_t[r]), 2'b01, 2'b10, 2'b00, 1'b0, 1'b1);
         do_start(14'd2);
         wait_cyc(3); press = 2'b10;
         wait_go(n);
         wait_cyc(4 * best_t[r]); press = 2'b11;
         wait_idle(saw);
         press = 2'b00; wait_cyc(2);
      end
`ifdef BEST_TIME_EN
      check("best_valid", best_valid, 2'b01);
      check("best_time0", best_time[T_W-1:0], 4);
`endif

      // Abort in DELAY returns to IDLE without a done pulse
      do_start(14'd5);
      wait_cyc(5); abort = 1'b1;
      wait_cyc(1); abort = 1'b0;
      check("abort_to_idle", {go, busy, valid, false_start}, 0);
      d0 = done_cnt;
      wait_cyc(60);
      check("abort_no_done", done_cnt, d0);

      // Zero delay: go one cycle after DELAY entry; ch1 faster wins
      push_exp(10'd2, 10'd3, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1);
      do_start(14'd0);
      wait_go(n);
      check("go_latency_d0", n, 2);
      wait_cyc(8); press = 2'b10;
      wait_cyc(4); press = 2'b11;
      wait_idle(saw);
      press = 2'b00;
      wait_cyc(5);

      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
